// File: rtl/fifo_param_pkg.sv
// fifo_param shared definitions
// default geometry and read-mode constants
package fifo_param_pkg;

  localparam int DATA_WIDTH_DEF = 4;
  localparam int ADDR_WIDTH_DEF = 3;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

endpackage

// File: rtl/fifo_mem.sv
// fifo storage array
// sync write port, async read port
module fifo_mem
  import fifo_param_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// parametrised single-clock fifo
// thresholds, sticky errors, optional fwft
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int FWFT       = FIFO_STD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic [ADDR_WIDTH:0]   af_thr,
  input  logic [ADDR_WIDTH:0]   ae_thr,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almostFull,
  output logic                  almostEmpty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   fifo_counter
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] DEPTH_V =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE =
    ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE =
    (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_set;
  logic                  unf_set;

  // flags straight off the registered count
  assign full        = (cnt == DEPTH_V);
  assign empty       = (cnt == '0);
  assign almostFull  = (cnt >= af_thr);
  assign almostEmpty = (cnt <= ae_thr);
  assign fifo_counter = cnt;

  // a read frees a slot for a write when full
  assign wr_acc  = wr_en & (~full | rd_en);
  assign rd_acc  = rd_en & ~empty;
  assign ovf_set = wr_en & full & ~rd_en;
  assign unf_set = rd_en & empty;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (DataIn),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // occupancy: simultaneous accept holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      unique case (1'b1)
        (wr_acc & ~rd_acc): cnt <= cnt + CNT_ONE;
        (rd_acc & ~wr_acc): cnt <= cnt - CNT_ONE;
        default:            cnt <= cnt;
      endcase
    end
  end

  // sticky errors, new error beats clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
    end
  end

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign DataOut = empty ? '0 : rdata;
    assign valid   = ~empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q;

    // registered read, held between reads
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) begin
          dout_q <= rdata;
        end
      end
    end

    assign DataOut = dout_q;
    assign valid   = valid_q;
  end

endmodule

// File: tb/tb_fifo_param.sv
// directed bench for fifo_param
// std instance plus fwft instance
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] din = '0;
  logic [3:0] af_thr = 4'd6;
  logic [3:0] ae_thr = 4'd1;
  logic       clr_err = 1'b0;
  logic [3:0] dout;
  logic       valid, full, empty, af, ae, ovf, unf;
  logic [3:0] cnt;

  logic       wr2 = 1'b0;
  logic       rd2 = 1'b0;
  logic [3:0] din2 = '0;
  logic [3:0] dout2;
  logic       valid2, full2, empty2, af2, ae2, ovf2, unf2;
  logic [3:0] cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_param #(.DATA_WIDTH(4), .ADDR_WIDTH(3), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .DataIn(din), .af_thr(af_thr), .ae_thr(ae_thr),
    .clr_err(clr_err), .DataOut(dout), .valid(valid),
    .full(full), .empty(empty), .almostFull(af),
    .almostEmpty(ae), .overflow(ovf), .underflow(unf),
    .fifo_counter(cnt)
  );

  fifo_param #(.DATA_WIDTH(4), .ADDR_WIDTH(3), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .wr_en(wr2), .rd_en(rd2),
    .DataIn(din2), .af_thr(af_thr), .ae_thr(ae_thr),
    .clr_err(clr_err), .DataOut(dout2), .valid(valid2),
    .full(full2), .empty(empty2), .almostFull(af2),
    .almostEmpty(ae2), .overflow(ovf2), .underflow(unf2),
    .fifo_counter(cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", cnt); end
    checks++; if ({full, empty, af, ae} !== 4'b0101) begin errors++; $display("FAIL rst_flags got %b exp 0101", {full, empty, af, ae}); end
    checks++; if ({valid, ovf, unf} !== 3'b000) begin errors++; $display("FAIL rst_vou got %b exp 000", {valid, ovf, unf}); end
    checks++; if (dout !== 4'd0) begin errors++; $display("FAIL rst_dout got %0d exp 0", dout); end
    af_thr = 4'd0;
    #1;
    checks++; if (af !== 1'b1) begin errors++; $display("FAIL rst_af0 got %b exp 1", af); end
    af_thr = 4'd6;
    #1;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_push_pop();
    wr_en = 1'b1;
    din = 4'd1; tick();
    din = 4'd2; tick();
    wr_en = 1'b0;
    checks++; if (cnt !== 4'd2) begin errors++; $display("FAIL pp_cnt2 got %0d exp 2", cnt); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++; if (dout !== 4'd1) begin errors++; $display("FAIL pp_dout got %0d exp 1", dout); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL pp_valid got %b exp 1", valid); end
    checks++; if (cnt !== 4'd1 || ae !== 1'b1) begin errors++; $display("FAIL pp_cnt_ae got %0d/%b exp 1/1", cnt, ae); end
    tick();
    checks++; if (valid !== 1'b0 || dout !== 4'd1) begin errors++; $display("FAIL pp_hold got %b/%0d exp 0/1", valid, dout); end
  endtask

  task automatic test_fill();
    wr_en = 1'b1;
    for (int v = 3; v <= 9; v++) begin
      din = 4'(v);
      tick();
      checks++;
      if (af !== (v - 1 >= 6)) begin
        errors++;
        $display("FAIL fill_af cnt=%0d got %b exp %b", cnt, af, (v - 1 >= 6));
      end
    end
    checks++; if (cnt !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL fill_full got %0d/%b exp 8/1", cnt, full); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fill_ovf0 got %b exp 0", ovf); end
    din = 4'd10; tick();
    wr_en = 1'b0;
    checks++; if (ovf !== 1'b1 || cnt !== 4'd8) begin errors++; $display("FAIL fill_ovf got %b/%0d exp 1/8", ovf, cnt); end
  endtask

  task automatic test_full_rw();
    logic [3:0] exp_q [8];
    for (int i = 0; i < 7; i++) exp_q[i] = 4'(i + 3);
    exp_q[7] = 4'd11;
    wr_en = 1'b1; rd_en = 1'b1; din = 4'd11;
    tick();
    wr_en = 1'b0;
    checks++; if (dout !== 4'd2 || cnt !== 4'd8) begin errors++; $display("FAIL frw got %0d/%0d exp 2/8", dout, cnt); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (dout !== exp_q[i] || valid !== 1'b1) begin
        errors++;
        $display("FAIL drain[%0d] got %0d/%b exp %0d/1", i, dout, valid, exp_q[i]);
      end
    end
    rd_en = 1'b0;
    checks++; if (empty !== 1'b1 || cnt !== 4'd0) begin errors++; $display("FAIL drain_empty got %b/%0d exp 1/0", empty, cnt); end
  endtask

  task automatic test_underflow();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b exp 0", ovf); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++; if (unf !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL unf got %b/%b exp 1/0", unf, valid); end
    checks++; if (dout !== 4'd11) begin errors++; $display("FAIL unf_hold got %0d exp 11", dout); end
    rd_en = 1'b1; clr_err = 1'b1; tick();
    rd_en = 1'b0;
    checks++; if (unf !== 1'b1) begin errors++; $display("FAIL unf_wins got %b exp 1", unf); end
    tick(); clr_err = 1'b0;
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL unf_clr got %b exp 0", unf); end
    wr_en = 1'b1; rd_en = 1'b1; din = 4'd7; tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (cnt !== 4'd1 || unf !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL emp_rw got %0d/%b/%b exp 1/1/0", cnt, unf, valid); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++; if (dout !== 4'd7 || cnt !== 4'd0) begin errors++; $display("FAIL emp_rw_pop got %0d/%0d exp 7/0", dout, cnt); end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
  endtask

  task automatic test_wrap();
    int bad;
    bad = 0;
    wr_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din = 4'(k); tick();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      din = 4'(k + 4);
      tick();
      if (dout !== 4'(k) || cnt !== 4'd4 || valid !== 1'b1) begin
        bad++;
        $display("FAIL wrap[%0d] got %0d/%0d exp %0d/4", k, dout, cnt, 4'(k));
      end
    end
    wr_en = 1'b0;
    for (int k = 20; k < 24; k++) begin
      tick();
      if (dout !== 4'(k)) begin
        bad++;
        $display("FAIL wrap_tail[%0d] got %0d exp %0d", k, dout, 4'(k));
      end
    end
    rd_en = 1'b0;
    checks++; if (bad != 0) errors++;
    checks++; if (empty !== 1'b1 || unf !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL wrap_end got %b/%b/%b exp 1/0/0", empty, unf, ovf); end
  endtask

  task automatic test_fwft();
    checks++; if (valid2 !== 1'b0 || empty2 !== 1'b1) begin errors++; $display("FAIL fw_idle got %b/%b exp 0/1", valid2, empty2); end
    wr2 = 1'b1; din2 = 4'd5; tick(); wr2 = 1'b0;
    checks++; if (dout2 !== 4'd5 || valid2 !== 1'b1) begin errors++; $display("FAIL fw_head got %0d/%b exp 5/1", dout2, valid2); end
    tick();
    checks++; if (dout2 !== 4'd5 || cnt2 !== 4'd1) begin errors++; $display("FAIL fw_keep got %0d/%0d exp 5/1", dout2, cnt2); end
    rd2 = 1'b1; tick(); rd2 = 1'b0;
    checks++; if (empty2 !== 1'b1 || valid2 !== 1'b0) begin errors++; $display("FAIL fw_pop got %b/%b exp 1/0", empty2, valid2); end
  endtask

  task automatic test_async_reset();
    wr_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din = 4'(k + 9); tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    wr_en = 1'b1; din = 4'd3; tick(); wr_en = 1'b0;
    checks++; if (cnt !== 4'd5 || valid !== 1'b0) begin errors++; $display("FAIL ar_pre got %0d/%b exp 5/0", cnt, valid); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (cnt !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL ar_cnt got %0d/%b/%b exp 0/1/0", cnt, empty, full); end
    checks++; if (dout !== 4'd0 || valid !== 1'b0) begin errors++; $display("FAIL ar_dout got %0d/%b exp 0/0", dout, valid); end
    checks++; if ({af, ae, ovf, unf} !== 4'b0100) begin errors++; $display("FAIL ar_flags got %b exp 0100", {af, ae, ovf, unf}); end
    #3;
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_fill();
    test_full_rw();
    test_underflow();
    test_wrap();
    test_fwft();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
